piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, data word width in bits (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 0, bit order (0 = LSB first, 1 = MSB first).
REQ-003 SHALL provide localparam CW = $clog2(WIDTH+2), the bit-counter width.
REQ-004 Clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-low.
REQ-006 En  input  1  block enable; when low, no load or shift is performed.
REQ-007 Ld  input  1  parallel-load request.
REQ-008 Shift  input  1  serial-advance request.
REQ-009 I  input  WIDTH  parallel data word.
REQ-010 D_Out_Bit  output  1  current serial bit, registered.
REQ-011 Valid_Bit_Out  output  1  one-cycle strobe qualifying D_Out_Bit.
REQ-012 Last_Bit  output  1  one-cycle strobe on the final bit of the frame.
REQ-013 Busy  output  1  high while frame bits remain (state ACTIVE).
REQ-014 Bit_Cnt  output  CW  number of bits still to send.

Function
REQ-015 SHALL implement two states: IDLE (Bit_Cnt = 0) and ACTIVE (Bit_Cnt > 0); Busy SHALL equal (state == ACTIVE).
REQ-016 Frame length N SHALL equal WIDTH, or WIDTH+1 when parity is compiled in (REQ-029).
REQ-017 Priority per edge with En = 1: Ld over Shift, Shift over hold.
REQ-018 En = 1 and Ld = 1 in any state: capture I into the data register; Bit_Cnt <= N; state <= ACTIVE; Valid_Bit_Out <= 0; Last_Bit <= 0; D_Out_Bit holds.
REQ-019 Ld during ACTIVE SHALL abort the current frame without emitting further bits from it and SHALL restart the frame with the new word.
REQ-020 En = 1, Ld = 0, Shift = 1 in ACTIVE: D_Out_Bit <= next bit; Valid_Bit_Out <= 1; Bit_Cnt decrements by 1; Last_Bit <= 1 only when Bit_Cnt was 1; state <= IDLE when Bit_Cnt reaches 0.
REQ-021 The next bit SHALL be R[0] with a right shift and zero fill when MSB_FIRST = 0, and R[WIDTH-1] with a left shift and zero fill when MSB_FIRST = 1.
REQ-022 Latency: a bit SHALL appear on D_Out_Bit with Valid_Bit_Out = 1 on the edge that samples Shift = 1, so it is visible in the following cycle.
REQ-023 Shift = 1 in IDLE SHALL be ignored: Valid_Bit_Out <= 0, Last_Bit <= 0, D_Out_Bit holds, Bit_Cnt stays 0.
REQ-024 Any edge without a valid shift, including every edge with En = 0, SHALL clear Valid_Bit_Out and Last_Bit and SHALL hold the data register, Bit_Cnt, state and D_Out_Bit.
REQ-025 Valid_Bit_Out and Last_Bit SHALL never stay high for two cycles unless Shift is issued on consecutive cycles.

Reset
REQ-026 Rst = 0 SHALL immediately, without waiting for a clock edge, force: data register = 0, Bit_Cnt = 0, state = IDLE, D_Out_Bit = 0, Valid_Bit_Out = 0, Last_Bit = 0, Busy = 0, and the parity register = 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL accept no shifts until the next Ld.
REQ-028 Deassertion SHALL take effect at the first rising edge of Clk after Rst goes high.

Configuration
REQ-029 Macro SERIALIZER_PARITY_EN defined: on Ld, store the even parity (XOR of I); N = WIDTH+1; the final bit sent SHALL be the stored parity bit, and it carries Last_Bit.
REQ-030 SERIALIZER_PARITY_EN undefined: no parity register exists; N = WIDTH; the final data bit carries Last_Bit.

Verification (WIDTH = 4 unless stated)
REQ-031 Hold Rst = 0 mid-frame, asynchronously between clock edges -> all outputs read 0 before the next edge; Bit_Cnt = 0.
REQ-032 MSB_FIRST = 0, Ld with I = 4'b1011, then 4 Shift cycles -> D_Out_Bit sequence 1,1,0,1 with Valid_Bit_Out high on each; Last_Bit high on the 4th only; Busy low afterward.
REQ-033 MSB_FIRST = 1, same stimulus -> sequence 1,0,1,1; Bit_Cnt sequence 4,3,2,1,0.
REQ-034 Shift pulses in IDLE, and Shift with En = 0 during ACTIVE -> Valid_Bit_Out stays 0; D_Out_Bit and Bit_Cnt unchanged.
REQ-035 Ld 4'b1011, 2 shifts, then Ld 4'b0110 with Shift = 1 on the same edge, then 4 shifts -> load wins; Bit_Cnt = 4; sequence 0,1,1,0 (LSB first).
REQ-036 SERIALIZER_PARITY_EN defined, Ld 4'b1011, 5 shifts -> sequence 1,1,0,1,1; Last_Bit high on the 5th; a 6th shift is ignored.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a remaining-bit counter, valid and last strobes.
// Defining SERIALIZER_PARITY_EN appends a stored even-parity bit as the final bit of each frame.
module piso_serializer #(
    parameter  int WIDTH     = 4,
    parameter  int MSB_FIRST = 0,
    localparam int CW        = $clog2(WIDTH + 2)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Ld,
    input  logic             Shift,
    input  logic [WIDTH-1:0] I,
    output logic             D_Out_Bit,
    output logic             Valid_Bit_Out,
    output logic             Last_Bit,
    output logic             Busy,
    output logic [CW-1:0]    Bit_Cnt
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

`ifdef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH);
`endif
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic             dout_r;
    logic             dout_s;
    logic             valid_r;
    logic             valid_s;
    logic             last_r;
    logic             last_s;
    logic             head_s;
    logic             next_bit_s;

    assign head_s    = (MSB_FIRST != 0) ? data_r[WIDTH-1] : data_r[0];
    assign shifted_s = (MSB_FIRST != 0) ? {data_r[WIDTH-2:0], 1'b0} : {1'b0, data_r[WIDTH-1:1]};

`ifdef SERIALIZER_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction

    // Parity of the loaded word, sent once all data bits have gone out.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            parity_r <= 1'b0;
        end else if (En && Ld) begin
            parity_r <= even_parity(I);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign next_bit_s = (cnt_r == CNT_ONE) ? parity_r : head_s;
`else
    assign next_bit_s = head_s;
`endif

    // Next-state logic: load beats shift; strobes drop on any edge without a real shift.
    always_comb begin
        data_s  = data_r;
        cnt_s   = cnt_r;
        state_s = state_r;
        dout_s  = dout_r;
        valid_s = 1'b0;
        last_s  = 1'b0;
        if (En) begin
            if (Ld) begin
                data_s  = I;
                cnt_s   = FRAME_LEN;
                state_s = ACTIVE;
            end else if (Shift && (state_r == ACTIVE)) begin
                data_s  = shifted_s;
                dout_s  = next_bit_s;
                valid_s = 1'b1;
                cnt_s   = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    last_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    last_s  = 1'b0;
                    state_s = ACTIVE;
                end
            end else begin
                data_s = data_r;
            end
        end else begin
            data_s = data_r;
        end
    end

    // State and output registers, cleared asynchronously by Rst.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
            dout_r  <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            state_r <= state_s;
            dout_r  <= dout_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

    assign D_Out_Bit     = dout_r;
    assign Valid_Bit_Out = valid_r;
    assign Last_Bit      = last_r;
    assign Busy          = (state_r == ACTIVE);
    assign Bit_Cnt       = cnt_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share stimulus and are
// compared each cycle against a queue-based frame model.
module tb_piso_serializer;
    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 2);
`ifdef SERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             En = 1'b0;
    logic             Ld = 1'b0;
    logic             Shift = 1'b0;
    logic [WIDTH-1:0] I = 4'b0000;

    logic          dout_a, valid_a, last_a, busy_a;
    logic          dout_b, valid_b, last_b, busy_b;
    logic [CW-1:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    bit   qa[$];
    bit   qb[$];
    logic m_dout_a = 1'b0;
    logic m_dout_b = 1'b0;
    logic m_valid  = 1'b0;
    logic m_last   = 1'b0;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
        .Clk(Clk), .Rst(Rst), .En(En), .Ld(Ld), .Shift(Shift), .I(I),
        .D_Out_Bit(dout_a), .Valid_Bit_Out(valid_a), .Last_Bit(last_a),
        .Busy(busy_a), .Bit_Cnt(cnt_a)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
        .Clk(Clk), .Rst(Rst), .En(En), .Ld(Ld), .Shift(Shift), .I(I),
        .D_Out_Bit(dout_b), .Valid_Bit_Out(valid_b), .Last_Bit(last_b),
        .Busy(busy_b), .Bit_Cnt(cnt_b)
    );

    always #5 Clk = ~Clk;

    function automatic logic [13:0] obs();
        return {dout_a, dout_b, valid_a, valid_b, last_a, last_b, busy_a, busy_b, cnt_a, cnt_b};
    endfunction

    function automatic logic [13:0] expv();
        logic [CW-1:0] c;
        logic          b;
        c = CW'(qa.size());
        b = (qa.size() != 0);
        return {m_dout_a, m_dout_b, m_valid, m_valid, m_last, m_last, b, b, c, c};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_dout_a = 1'b0;
        m_dout_b = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
    endtask

    task automatic model_load(input logic [WIDTH-1:0] w);
        qa.delete();
        qb.delete();
        for (int i = 0; i < WIDTH; i++) begin
            qa.push_back(w[i]);
            qb.push_back(w[WIDTH-1-i]);
        end
`ifdef SERIALIZER_PARITY_EN
        qa.push_back(^w);
        qb.push_back(^w);
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
    task automatic step(input logic en, input logic ld, input logic sh, input logic [WIDTH-1:0] d);
        En = en;
        Ld = ld;
        Shift = sh;
        I = d;
        @(posedge Clk);
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (en && ld) begin
            model_load(d);
        end else if (en && sh && qa.size() > 0) begin
            m_dout_a = qa.pop_front();
            m_dout_b = qb.pop_front();
            m_valid  = 1'b1;
            m_last   = (qa.size() == 0);
        end
        #1;
    endtask

    task automatic test_reset();
        #2 Rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs() !== 14'd0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", obs(), 14'd0);
        end
        @(negedge Clk);
        Rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_directed();
        logic lsb_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic msb_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        step(1'b1, 1'b1, 1'b0, 4'b1011);
        total++;
        if (obs() !== expv() || cnt_b !== CW'(N)) begin
            bad++;
            $display("FAIL directed_load got=%h exp=%h", obs(), expv());
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b0000);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL directed_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            total++;
            if ({dout_a, dout_b, valid_a, cnt_b} !== {lsb_seq[k], msb_seq[k], 1'b1, CW'(N - 1 - k)}) begin
                bad++;
                $display("FAIL directed_seq k=%0d got=%b%b%b cnt=%0d exp=%b%b1 cnt=%0d",
                         k, dout_a, dout_b, valid_a, cnt_b, lsb_seq[k], msb_seq[k], N - 1 - k);
            end
        end
        for (int k = 4; k < N; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b0000);
        end
        total++;
        if (obs() !== expv() || busy_a !== 1'b0 || last_a !== 1'b1) begin
            bad++;
            $display("FAIL directed_end got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_idle_and_enable();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b1111);
            total++;
            if (obs() !== expv() || valid_a !== 1'b0) begin
                bad++;
                $display("FAIL idle_shift k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        step(1'b1, 1'b1, 1'b0, 4'b0110);
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 4'b0000);
            total++;
            if (obs() !== expv() || cnt_a !== CW'(N - 1) || dout_a !== 1'b0) begin
                bad++;
                $display("FAIL en_low k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        step(1'b0, 1'b1, 1'b0, 4'b1111);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL en_low_load got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_load_priority();
        logic seq[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        step(1'b1, 1'b1, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 1'b1, 4'b0110);
        total++;
        if (obs() !== expv() || cnt_a !== CW'(N) || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL ld_wins got=%h exp=%h", obs(), expv());
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b0000);
            total++;
            if (obs() !== expv() || dout_a !== seq[k]) begin
                bad++;
                $display("FAIL ld_restart k=%0d got=%h exp=%h bit=%b want=%b", k, obs(), expv(), dout_a, seq[k]);
            end
        end
        for (int k = 4; k < N; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b0000);
        end
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic seq[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        step(1'b1, 1'b1, 1'b0, 4'b1011);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b1, 4'b0000);
            total++;
            if (obs() !== expv() || dout_a !== seq[k] || last_a !== (k == 4)) begin
                bad++;
                $display("FAIL parity k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        total++;
        if (obs() !== expv() || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL parity_extra got=%h exp=%h", obs(), expv());
        end
    endtask
`endif

    task automatic test_mid_reset();
        step(1'b1, 1'b1, 1'b0, 4'b1101);
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        #2 Rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs() !== 14'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", obs(), 14'd0);
        end
        #2 Rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, 4'b0000);
        total++;
        if (obs() !== expv() || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_shift got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic en, ld, sh;
        logic [WIDTH-1:0] d;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 7) == 0);
            sh = ($urandom_range(0, 3) != 0);
            d  = WIDTH'($urandom);
            step(en, ld, sh, d);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_and_enable();
        test_load_priority();
`ifdef SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
